vga_bounce_box: RTL and testbench

Pixel-generation stage sitting directly downstream of the 800x600@72Hz VGA timing generator. It consumes the raw horizontal/vertical counters and the (active-low) sync outputs. It renders a square box that bounces off the screen edges, moving once per frame, over a solid background. It re-times sync through the same pipeline as colour so the DAC pins see aligned RGB/HS/VS.

---
 rtl/vga_bounce_box.sv | 134 +++++++++++++
 tb/tb_vga_bounce_box.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: two-stage pixel pipeline drawing a bouncing box over a solid background.
// Optional VGA_BOX_BORDER_EN adds a 2-pixel white border around the box.
module vga_bounce_box #(
    parameter int         H_ACTIVE  = 800,
    parameter int         V_ACTIVE  = 600,
    parameter int         BOX_SIZE  = 32,
    parameter int         STEP      = 2,
    parameter logic [2:0] BG_COLOR  = 3'b001,
    parameter logic [2:0] BOX_COLOR = 3'b110
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [10:0] HOR_CNT,
    input  logic [9:0]  VER_CNT,
    input  logic        HS_IN,
    input  logic        VS_IN,
    input  logic        PAUSE,
    output logic        VGA_RED,
    output logic        VGA_GREEN,
    output logic        VGA_BLUE,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        FRAME_TICK
);
    localparam logic [11:0] HA = 12'(H_ACTIVE);
    localparam logic [11:0] VA = 12'(V_ACTIVE);
    localparam logic [11:0] BS = 12'(BOX_SIZE);
    localparam logic [11:0] ST = 12'(STEP);

    typedef enum logic [1:0] {S_RUN, S_UPD_X, S_UPD_Y} state_t;

    state_t      state, state_nxt;
    logic [10:0] box_x, s1_h;
    logic [9:0]  box_y, s1_v;
    logic        dir_x, dir_y, pause_hold;
    logic        s1_act, s1_hs, s1_vs, s1_tick;
    logic        tick_in, hit_x, hit_y, in_box;
    logic [11:0] hc, vc, bx, by, h2, v2;
    logic [2:0]  box_rgb, rgb_nxt;

    assign hc      = {1'b0, HOR_CNT};
    assign vc      = {2'b0, VER_CNT};
    assign bx      = {1'b0, box_x};
    assign by      = {2'b0, box_y};
    assign h2      = {1'b0, s1_h};
    assign v2      = {2'b0, s1_v};
    assign tick_in = (vc == VA) && (hc == 12'd0);
    // Bounce detection at 12 bits so the edge sum cannot wrap
    assign hit_x   = dir_x ? (bx + BS + ST >= HA) : (bx <= ST);
    assign hit_y   = dir_y ? (by + BS + ST >= VA) : (by <= ST);

    always_comb begin
        state_nxt = state;
        state_nxt = (state == S_RUN)   ? (tick_in ? S_UPD_X : S_RUN) :
                    (state == S_UPD_X) ? S_UPD_Y : S_RUN;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_RUN;
            pause_hold <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN && tick_in)
                pause_hold <= PAUSE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (!pause_hold) begin
            if (state == S_UPD_X) begin
                box_x <= dir_x ? (hit_x ? 11'(HA - BS) : box_x + 11'(ST))
                               : (hit_x ? 11'd0 : box_x - 11'(ST));
                dir_x <= hit_x ? ~dir_x : dir_x;
            end
            if (state == S_UPD_Y) begin
                box_y <= dir_y ? (hit_y ? 10'(VA - BS) : box_y + 10'(ST))
                               : (hit_y ? 10'd0 : box_y - 10'(ST));
                dir_y <= hit_y ? ~dir_y : dir_y;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_h    <= '0;
            s1_v    <= '0;
            s1_act  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_tick <= 1'b0;
        end else begin
            s1_h    <= HOR_CNT;
            s1_v    <= VER_CNT;
            s1_act  <= (hc < HA) && (vc < VA);
            s1_hs   <= HS_IN;
            s1_vs   <= VS_IN;
            s1_tick <= tick_in;
        end
    end

    assign in_box = (h2 >= bx) && (h2 < bx + BS) && (v2 >= by) && (v2 < by + BS);

`ifdef VGA_BOX_BORDER_EN
    logic [11:0] off_x, off_y;
    assign off_x   = h2 - bx;
    assign off_y   = v2 - by;
    assign box_rgb = (off_x < 12'd2 || off_x >= BS - 12'd2 || off_y < 12'd2 || off_y >= BS - 12'd2)
                     ? 3'b111 : BOX_COLOR;
`else
    assign box_rgb = BOX_COLOR;
`endif

    assign rgb_nxt = !s1_act ? 3'b000 : in_box ? box_rgb : BG_COLOR;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            {VGA_RED, VGA_GREEN, VGA_BLUE} <= 3'b000;
            VGA_HS     <= 1'b1;
            VGA_VS     <= 1'b1;
            FRAME_TICK <= 1'b0;
        end else begin
            {VGA_RED, VGA_GREEN, VGA_BLUE} <= rgb_nxt;
            VGA_HS     <= s1_hs;
            VGA_VS     <= s1_vs;
            FRAME_TICK <= s1_tick;
        end
    end
endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box: scoreboard bench driving synthetic counters, one frame tick per short burst.
module tb_vga_bounce_box;
    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [10:0] HOR_CNT  = '0;
    logic [9:0]  VER_CNT  = '0;
    logic        HS_IN    = 1'b1;
    logic        VS_IN    = 1'b1;
    logic        PAUSE    = 1'b0;
    logic        VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, FRAME_TICK;

    vga_bounce_box dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .HOR_CNT(HOR_CNT), .VER_CNT(VER_CNT),
        .HS_IN(HS_IN), .VS_IN(VS_IN), .PAUSE(PAUSE),
        .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [5:0] val;
        int         h;
        int         v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0, errors = 0;
    int   bx = 0, by = 0;
    bit   dx = 1'b1, dy = 1'b1;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b (rgb,hs,vs,tick)", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_rgb(input int h, input int v);
        if (h >= 800 || v >= 600) return 3'b000;
        if (h >= bx && h < bx + 32 && v >= by && v < by + 32) begin
`ifdef VGA_BOX_BORDER_EN
            if (h - bx < 2 || h - bx > 29 || v - by < 2 || v - by > 29) return 3'b111;
`endif
            return 3'b110;
        end
        return 3'b001;
    endfunction

    task automatic model_update();
        if (dx) begin
            if (bx + 34 >= 800) begin bx = 768; dx = 1'b0; end
            else bx += 2;
        end else begin
            if (bx <= 2) begin bx = 0; dx = 1'b1; end
            else bx -= 2;
        end
        if (dy) begin
            if (by + 34 >= 600) begin by = 568; dy = 1'b0; end
            else by += 2;
        end else begin
            if (by <= 2) begin by = 0; dy = 1'b1; end
            else by -= 2;
        end
    endtask

    task automatic cyc(input int h, input int v, input bit hs = 1'b1, input bit vs = 1'b1,
                       input bit p = 1'b0);
        bit tick;
        @(negedge CLOCK_50);
        HOR_CNT = h[10:0];
        VER_CNT = v[9:0];
        HS_IN   = hs;
        VS_IN   = vs;
        PAUSE   = p;
        tick    = (h == 0 && v == 600);
        q.push_back('{{model_rgb(h, v), hs, vs, tick}, h, v});
        if (tick && !p) model_update();
    endtask

    // Tick, let the update settle in blanking, then probe around the box edges
    task automatic frame(input bit p = 1'b0);
        cyc(0, 600, 1'b1, 1'b1, p);
        repeat (3) cyc(0, 601);
        cyc(bx, by);
        cyc(bx + 31, by + 31);
        cyc(bx + 1, by + 16);
        cyc(bx + 5, by + 5);
        if (bx > 0) cyc(bx - 1, by);
        if (bx + 32 < 800) cyc(bx + 32, by);
        if (by > 0) cyc(bx, by - 1);
        if (by + 32 < 600) cyc(bx, by + 32);
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (RESET_N && q.size() >= 2) begin
            e = q.pop_front();
            check($sformatf("px h=%0d v=%0d", e.h, e.v),
                  {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, FRAME_TICK}, e.val);
        end
    end

    initial begin
        #12;
        check("reset", {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, FRAME_TICK}, 6'b000110);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        cyc(0, 0);
        cyc(32, 0);
        cyc(800, 0);
        cyc(31, 31);
        cyc(32, 32);
        cyc(1, 1);
        cyc(5, 5);
        for (int h = 850; h <= 980; h++) cyc(h, 10, !(h >= 856 && h <= 975));
        for (int v = 600; v <= 606; v++) cyc(100, v, 1'b1, !(v >= 601 && v <= 603));
        for (int i = 1; i <= 390; i++) frame();
        repeat (3) frame(1'b1);
        frame();
        cyc(0, 600);
        @(posedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        HOR_CNT = 11'd0;
        VER_CNT = 10'd601;
        #1;
        check("async_rst", {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, FRAME_TICK}, 6'b000110);
        q.delete();
        bx = 0;
        by = 0;
        dx = 1'b1;
        dy = 1'b1;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        cyc(0, 0);
        cyc(1, 1);
        cyc(5, 5);
        cyc(32, 0);
        frame();
        frame();
        repeat (3) cyc(0, 601);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
